// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register and writeback select for the 5-stage MIPS
//   datapath. Each cycle it captures the MEM-stage read data, ALU result,
//   destination register and control. It then drives the register-file
//   write port one cycle later.
//
//   Update priority on every rising edge: rst > flush > stall > normal load.
//
// Parameters
//   DATA_W  data path / register-file write data width
//   REG_W   register index width
//   CNT_W   retired-instruction counter width (wraps modulo 2^CNT_W)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   stall           hold every stage register and the counter
//   flush           insert a bubble (valid and write enable cleared)
//   MEM_*           MEM-stage read data, ALU result, destination, control
//   WB_WriteData    register-file write data (memory data or ALU result)
//   WB_RegDest      register-file write address
//   WB_RegWrite     register-file write enable, never asserted for $zero
//   WB_Valid        WB stage holds a real instruction
//   retire_count    instructions captured into WB since reset
//
// Optional feature (macro MEMWB_FWD_EN)
//   Adds fwd_valid / fwd_reg / fwd_data for EX-stage forwarding. These
//   mirror the write port and are forced to 0 in the cycle after reset.
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] MEM_ReadData,
  input  logic [DATA_W-1:0] MEM_ALU_result,
  input  logic [REG_W-1:0]  MEM_RegDest,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_Valid,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic [REG_W-1:0]  WB_RegDest,
  output logic              WB_RegWrite,
  output logic              WB_Valid,
  output logic [CNT_W-1:0]  retire_count
`ifdef MEMWB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [REG_W-1:0]  dst_q;
  logic              rw_q;
  logic              m2r_q;
  logic              v_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic              m2r,
    input logic [DATA_W-1:0] rd,
    input logic [DATA_W-1:0] alu
  );
    return m2r ? rd : alu;
  endfunction

  // MEM -> WB register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      alu_q <= '0;
      dst_q <= '0;
      rw_q  <= 1'b0;
      m2r_q <= 1'b0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      // Data, destination and select are left alone: the write enable and
      // valid bit are what make the entry a bubble.
      v_q  <= 1'b0;
      rw_q <= 1'b0;
    end else if (!stall) begin
      rd_q  <= MEM_ReadData;
      alu_q <= MEM_ALU_result;
      dst_q <= MEM_RegDest;
      rw_q  <= MEM_RegWrite;
      m2r_q <= MEM_MemtoReg;
      v_q   <= MEM_Valid;
      // Every real instruction counts, including stores and branches.
      if (MEM_Valid) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign WB_WriteData = wb_select(m2r_q, rd_q, alu_q);
  assign WB_RegDest   = dst_q;
  assign WB_Valid     = v_q;
  assign WB_RegWrite  = rw_q & v_q & (dst_q != '0);
  assign retire_count = cnt_q;

`ifdef MEMWB_FWD_EN
  logic rst_d_q;

  always_ff @(posedge clk) begin
    rst_d_q <= rst;
  end

  assign fwd_valid = rst_d_q ? 1'b0 : WB_RegWrite;
  assign fwd_reg   = rst_d_q ? '0   : WB_RegDest;
  assign fwd_data  = rst_d_q ? '0   : WB_WriteData;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Scoreboard bench for mem_wb_stage (CNT_W=4 so the counter wraps quickly).
//   The driver applies one input set per cycle on the falling edge. It pushes
//   the expected post-edge outputs, taken from a behavioural model of the
//   stage, into a queue. The monitor pops one entry after every rising edge
//   and compares.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] MEM_ReadData;
  logic [DATA_W-1:0] MEM_ALU_result;
  logic [REG_W-1:0]  MEM_RegDest;
  logic              MEM_RegWrite;
  logic              MEM_MemtoReg;
  logic              MEM_Valid;
  logic [DATA_W-1:0] WB_WriteData;
  logic [REG_W-1:0]  WB_RegDest;
  logic              WB_RegWrite;
  logic              WB_Valid;
  logic [CNT_W-1:0]  retire_count;
`ifdef MEMWB_FWD_EN
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_reg;
  logic [DATA_W-1:0] fwd_data;
`endif

  mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .MEM_ReadData   (MEM_ReadData),
    .MEM_ALU_result (MEM_ALU_result),
    .MEM_RegDest    (MEM_RegDest),
    .MEM_RegWrite   (MEM_RegWrite),
    .MEM_MemtoReg   (MEM_MemtoReg),
    .MEM_Valid      (MEM_Valid),
    .WB_WriteData   (WB_WriteData),
    .WB_RegDest     (WB_RegDest),
    .WB_RegWrite    (WB_RegWrite),
    .WB_Valid       (WB_Valid),
    .retire_count   (retire_count)
`ifdef MEMWB_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic              wen;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
    logic              known;   // data/dst defined (not after a flush)
    logic [CNT_W-1:0]  cnt;
    logic              after_rst;
    string             tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of what WB shows after the coming edge.
  task automatic step(input string tag, input logic r, input logic f, input logic s,
                      input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] alu,
                      input logic [REG_W-1:0] dst, input logic rw, input logic m2r,
                      input logic v);
    @(negedge clk);
    rst = r; flush = f; stall = s;
    MEM_ReadData = rd; MEM_ALU_result = alu; MEM_RegDest = dst;
    MEM_RegWrite = rw; MEM_MemtoReg = m2r; MEM_Valid = v;
    if (r) begin
      model.valid = 0; model.wen = 0; model.dst = 0; model.data = 0;
      model.known = 1; model.cnt = 0;
    end else if (f) begin
      model.valid = 0; model.wen = 0; model.known = 0;
    end else if (!s) begin
      model.valid = v;
      model.wen   = rw && v && (dst != 0);
      model.dst   = dst;
      model.data  = m2r ? rd : alu;
      model.known = 1;
      model.cnt   = CNT_W'((int'(model.cnt) + (v ? 1 : 0)) % (1 << CNT_W));
    end
    model.after_rst = r;
    model.tag = tag;
    exp_q.push_back(model);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare after every rising edge once stimulus is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".valid"}, 64'(WB_Valid), 64'(e.valid));
        chk({e.tag, ".regwrite"}, 64'(WB_RegWrite), 64'(e.wen));
        chk({e.tag, ".count"}, 64'(retire_count), 64'(e.cnt));
        if (e.known) begin
          chk({e.tag, ".data"}, 64'(WB_WriteData), 64'(e.data));
          chk({e.tag, ".dest"}, 64'(WB_RegDest), 64'(e.dst));
        end
`ifdef MEMWB_FWD_EN
        chk({e.tag, ".fwd_valid"}, 64'(fwd_valid), e.after_rst ? 64'd0 : 64'(e.wen));
        if (e.known || e.after_rst) begin
          chk({e.tag, ".fwd_reg"}, 64'(fwd_reg), e.after_rst ? 64'd0 : 64'(e.dst));
          chk({e.tag, ".fwd_data"}, 64'(fwd_data), e.after_rst ? 64'd0 : 64'(e.data));
        end
`endif
      end
    end
  end

  initial begin
    rst = 1; stall = 0; flush = 0;
    MEM_ReadData = '0; MEM_ALU_result = '0; MEM_RegDest = '0;
    MEM_RegWrite = 0; MEM_MemtoReg = 0; MEM_Valid = 0;
    model = '{valid:0, wen:0, dst:0, data:0, known:1, cnt:0, after_rst:1, tag:"init"};

    // Reset with arbitrary inputs present
    step("reset0", 1, 0, 0, 32'hFFFF_FFFF, 32'hAAAA_5555, 5'd31, 1, 1, 1);
    step("reset1", 1, 0, 0, 32'h1357_9BDF, 32'h0246_8ACE, 5'd7, 1, 0, 1);

    // ALU writeback, load writeback, $zero suppression
    step("alu_wb",  0, 0, 0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8, 1, 0, 1);
    step("load_wb", 0, 0, 0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8, 1, 1, 1);
    step("zero_wb", 0, 0, 0, 32'h0000_00AA, 32'h0000_00BB, 5'd0, 1, 0, 1);
    step("invalid", 0, 0, 0, 32'h0000_0011, 32'h0000_0022, 5'd3, 1, 0, 0);
    step("store",   0, 0, 0, 32'h0000_0011, 32'h0000_0022, 5'd3, 0, 0, 1);

    // Stall holds an r9 entry, then flush overrides a simultaneous stall
    step("load_r9", 0, 0, 0, 32'h0000_0099, 32'h0000_0909, 5'd9, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 0, 1, $urandom, $urandom, 5'(i + 20), 1, 1, 1);
    step("flush_stall", 0, 1, 1, $urandom, $urandom, 5'd12, 1, 0, 1);
    step("after_flush", 0, 0, 0, 32'h0000_0001, 32'h0000_0002, 5'd4, 1, 1, 1);

    // Reset during a stall discards the held entry
    step("stall_pre", 0, 0, 1, 32'h5, 32'h6, 5'd5, 1, 0, 1);
    step("rst_in_stall", 1, 0, 1, 32'h5, 32'h6, 5'd5, 1, 0, 1);

    // Counter wrap: 16 valid loads interleaved with invalid cycles
    for (int i = 0; i < 16; i++) begin
      step("wrap_v", 0, 0, 0, $urandom, $urandom, 5'($urandom_range(0, 31)), 1, i[0], 1);
      step("wrap_nv", 0, 0, 0, $urandom, $urandom, 5'd1, 1, 0, 0);
    end

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0),
           $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain.queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback select for the 5-stage MIPS datapath.
- Sits directly downstream of the MEM stage and captures its read data, ALU result, destination register and control each cycle.
- Drives the register-file write port (data, address, enable).
- Supports stall (hold), flush (bubble), a per-entry valid bit and a retired-instruction counter.

Parameters:
- DATA_W, 32, width of the data path and of the register-file write data.
- REG_W, 5, width of the register index.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold all stage registers.
- flush  input  1  load a bubble (valid=0, RegWrite=0).
- MEM_ReadData  input  DATA_W  data memory read data, combinationally valid in the same cycle as the MEM-stage inputs.
- MEM_ALU_result  input  DATA_W  ALU result passed through MEM.
- MEM_RegDest  input  REG_W  destination register index.
- MEM_RegWrite  input  1  register write enable from control.
- MEM_MemtoReg  input  1  1 selects memory data, 0 selects ALU result.
- MEM_Valid  input  1  MEM stage holds a real instruction.
- WB_WriteData  output  DATA_W  register-file write data.
- WB_RegDest  output  REG_W  register-file write address.
- WB_RegWrite  output  1  register-file write enable.
- WB_Valid  output  1  WB stage holds a real instruction.
- retire_count  output  CNT_W  number of instructions retired since reset.

Behaviour:
- Internal registers: rd_q, alu_q, dst_q, rw_q, m2r_q, v_q.
- Update priority on each rising clk edge: rst > flush > stall > normal load.
- rst=1:
  - all internal registers clear to 0;
  - retire_count clears to 0;
  - outputs are 0 from the next cycle.
  - Reset mid-stall or mid-flush discards the held or in-flight entry.
- flush=1 (rst=0):
  - v_q and rw_q clear to 0;
  - data, dst and m2r registers may take any value, since outputs are gated;
  - flush overrides a simultaneous stall.
- stall=1 (rst=0, flush=0):
  - all registers hold;
  - retire_count holds.
- Normal load:
  - all registers capture the MEM_* inputs;
  - latency is exactly 1 cycle from MEM inputs to WB outputs.
- WB_WriteData is combinational from registers: m2r_q ? rd_q : alu_q.
- WB_RegDest = dst_q.
- WB_Valid = v_q.
- WB_RegWrite = rw_q & v_q & (dst_q != 0). A write to $zero is never asserted.
- retire_count:
  - increments by 1 on an edge where the normal-load path is taken and MEM_Valid=1;
  - counts capture into WB, not the write-enable, so stores and branches count;
  - wraps from 2^CNT_W-1 to 0;
  - no increment on stall, flush or rst edges.
- MEM_Valid=0 captured on a normal load gives WB_Valid=0 and WB_RegWrite=0, whatever MEM_RegWrite is.
- Outputs are stable for the full cycle; the register file writes on the next edge (or half-cycle, as the register file decides).

Optional Feature:
- Macro: MEMWB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_reg (REG_W) and fwd_data (DATA_W) for EX-stage forwarding.
  - fwd_valid = WB_RegWrite.
  - fwd_reg = WB_RegDest.
  - fwd_data = WB_WriteData.
  - All three are forced to 0 during the cycle after rst.
- Not defined: these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset check: rst=1 for 2 cycles with arbitrary inputs -> WB_WriteData=0, WB_RegDest=0, WB_RegWrite=0, WB_Valid=0, retire_count=0.
- ALU writeback: MEM_ALU_result=0x0000_1234, MEM_ReadData=0xDEAD_BEEF, MEM_RegDest=8, RegWrite=1, MemtoReg=0, Valid=1 -> next cycle WB_WriteData=0x1234, WB_RegDest=8, WB_RegWrite=1, retire_count=1.
- Load writeback: same inputs with MemtoReg=1 -> WB_WriteData=0xDEADBEEF.
- $zero suppression: RegDest=0, RegWrite=1 -> WB_RegWrite=0, WB_Valid=1, count increments.
- Stall then flush:
  - load an entry to r9, then stall=1 for 3 cycles with new inputs -> outputs and count unchanged;
  - then flush=1 and stall=1 together -> WB_Valid=0, WB_RegWrite=0, count unchanged.
- Counter wrap with CNT_W=4: 16 valid normal loads -> retire_count goes 15 then 0; interleaved MEM_Valid=0 cycles do not increment.
